// File: rtl/ula_pkg.sv
// ula_pkg: constants shared by the operand loader and the ALU stage.
//   - estado_t   : loader FSM encoding, also shown on the LEDs
//   - OP_*       : ALU selector codes (100-111 are unused)
//   - DEBOUNCE_CICLOS_PADRAO : simulation default for the key debouncer
package ula_pkg;

  typedef enum logic [1:0] {
    CARREGA_A  = 2'b00,
    CARREGA_B  = 2'b01,
    CARREGA_OP = 2'b10,
    VALIDO     = 2'b11
  } estado_t;

  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;

  // Board builds override this with 500000 (10 ms at 50 MHz).
  localparam int DEBOUNCE_CICLOS_PADRAO = 4;

endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: 2-flop synchronizer plus debouncer for an active-low key.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset (key treated as released)
//   key_n  : raw bouncing push-button, active-low, asynchronous
//   evento : one-cycle press pulse, high on the edge the stable level
//            goes 1->0 (releases produce nothing)
module debounce_botao
  import ula_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic evento
);

  localparam int CNT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic             sync1;
  logic             sync2;
  logic             estavel;
  logic [CNT_W-1:0] cnt;
  logic             muda;

  // The stable level flips on the edge where the DEBOUNCE_CICLOS-th
  // consecutive disagreeing sample is seen.
  assign muda = (sync2 != estavel) && (cnt == CNT_MAX);

  // NOTE: evento is decoded combinationally from registers so the FSM acts
  // on the very edge the stable level falls, not one cycle later.
  assign evento = muda && estavel;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      estavel <= 1'b1;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync1->sync2 a true two-stage
      // shift; blocking ones would collapse the synchronizer to one flop.
      sync1 <= key_n;
      sync2 <= sync1;
      if (sync2 == estavel) begin
        cnt <= '0;
      end else if (muda) begin
        estavel <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/carregador_operandos.sv
// carregador_operandos: loads A, B and the ALU selector/carry-in from
// switches, one key press per step, and holds the set until consumed.
//   clk, rst    : clock and synchronous active-high reset
//   key_n       : raw push-button (active-low)
//   sw_dados    : 4-bit operand switches (A or B)
//   sw_op       : 3-bit ALU selector switches
//   sw_cin      : carry-in switch
//   aceito      : downstream stage consumed the operand set
//   a, b        : registered operands
//   seletor,cin : registered ALU selector and carry-in
//   valido      : complete operand set available
//   op_invalida : valid set carries an unused selector (1xx)
//   estado      : current FSM state for the LEDs
module carregador_operandos
  import ula_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [3:0] sw_dados,
  input  logic [2:0] sw_op,
  input  logic       sw_cin,
  input  logic       aceito,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] seletor,
  output logic       cin,
  output logic       valido,
  output logic       op_invalida,
  output logic [1:0] estado
);

  estado_t state;
  logic    evento;

  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .evento(evento)
  );

  // Switches are quasi-static and read only on the event edge, so they are
  // deliberately not synchronized.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CARREGA_A;
      a       <= '0;
      b       <= '0;
      seletor <= '0;
      cin     <= 1'b0;
      valido  <= 1'b0;
    end else begin
      unique case (state)
        CARREGA_A: if (evento) begin
          a     <= sw_dados;
          state <= CARREGA_B;
        end
        CARREGA_B: if (evento) begin
          b     <= sw_dados;
          state <= CARREGA_OP;
        end
        CARREGA_OP: if (evento) begin
          seletor <= sw_op;
          cin     <= sw_cin;
          valido  <= 1'b1;
          state   <= VALIDO;
        end
        // Presses are dropped here, including one coinciding with aceito.
        VALIDO: if (aceito) begin
          valido <= 1'b0;
          state  <= CARREGA_A;
        end
        default: state <= CARREGA_A;
      endcase
    end
  end

  assign estado      = state;
  assign op_invalida = (state == VALIDO) && seletor[2];

endmodule

// File: tb/tb_carregador_operandos.sv
// tb_carregador_operandos: directed self-checking bench for the operand
// loader with DEBOUNCE_CICLOS=4 (press takes effect 6 edges after key_n
// is first sampled low).
module tb_carregador_operandos;
  import ula_pkg::*;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic [3:0] sw_dados;
  logic [2:0] sw_op;
  logic       sw_cin;
  logic       aceito;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] seletor;
  logic       cin;
  logic       valido;
  logic       op_invalida;
  logic [1:0] estado;

  int checks   = 0;
  int failures = 0;

  carregador_operandos #(
    .DEBOUNCE_CICLOS(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .sw_dados   (sw_dados),
    .sw_op      (sw_op),
    .sw_cin     (sw_cin),
    .aceito     (aceito),
    .a          (a),
    .b          (b),
    .seletor    (seletor),
    .cin        (cin),
    .valido     (valido),
    .op_invalida(op_invalida),
    .estado     (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Clean press: low long enough to register, then released and settled.
  task automatic press();
    key_n = 1'b0;
    tick(DEB + 2);
    key_n = 1'b1;
    tick(DEB + 4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {4'h0, a}, 8'h00);
    check({tag, "_b"}, {4'h0, b}, 8'h00);
    check({tag, "_sel"}, {5'h0, seletor}, 8'h00);
    check({tag, "_cin"}, {7'h0, cin}, 8'h00);
    check({tag, "_valido"}, {7'h0, valido}, 8'h00);
    check({tag, "_opinv"}, {7'h0, op_invalida}, 8'h00);
    check({tag, "_estado"}, {6'h0, estado}, 8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    key_n    = 1'b1;
    sw_dados = 4'h0;
    sw_op    = OP_SOMA;
    sw_cin   = 1'b0;
    aceito   = 1'b0;
    tick(2);
    check_all_zero("reset");

    // 3-cycle glitch in CARREGA_A: no event.
    rst      = 1'b0;
    sw_dados = 4'hA;
    key_n    = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(DEB + 4);
    check("glitch_estado", {6'h0, estado}, 8'h00);
    check("glitch_a", {4'h0, a}, 8'h00);

    // Key held low from edge 1: capture exactly at edge 6, only once.
    rst = 1'b1;
    tick(1);
    rst      = 1'b0;
    sw_dados = 4'h5;
    key_n    = 1'b0;
    tick(5);
    check("edge5_a", {4'h0, a}, 8'h00);
    check("edge5_estado", {6'h0, estado}, 8'h00);
    tick(1);
    check("edge6_a", {4'h0, a}, 8'h05);
    check("edge6_estado", {6'h0, estado}, 8'h01);
    sw_dados = 4'hC;
    tick(10);
    check("held_estado", {6'h0, estado}, 8'h01);
    check("held_b", {4'h0, b}, 8'h00);
    key_n = 1'b1;
    tick(DEB + 4);
    check("release_estado", {6'h0, estado}, 8'h01);

    // aceito outside VALIDO is ignored.
    aceito = 1'b1;
    tick(2);
    aceito = 1'b0;
    check("aceito_b_estado", {6'h0, estado}, 8'h01);

    // Full load sequence.
    sw_dados = 4'h3;
    press();
    check("load_b", {4'h0, b}, 8'h03);
    check("load_b_estado", {6'h0, estado}, 8'h02);
    sw_op  = OP_SUB;
    sw_cin = 1'b1;
    press();
    check("full_a", {4'h0, a}, 8'h05);
    check("full_b", {4'h0, b}, 8'h03);
    check("full_sel", {5'h0, seletor}, 8'h01);
    check("full_cin", {7'h0, cin}, 8'h01);
    check("full_valido", {7'h0, valido}, 8'h01);
    check("full_estado", {6'h0, estado}, 8'h03);
    check("full_opinv", {7'h0, op_invalida}, 8'h00);

    // Press in VALIDO is ignored.
    sw_dados = 4'h9;
    sw_op    = OP_AND;
    sw_cin   = 1'b0;
    press();
    check("ign_estado", {6'h0, estado}, 8'h03);
    check("ign_a", {4'h0, a}, 8'h05);
    check("ign_b", {4'h0, b}, 8'h03);
    check("ign_sel", {5'h0, seletor}, 8'h01);
    check("ign_cin", {7'h0, cin}, 8'h01);

    // aceito on the same edge as a press event: aceito wins, no capture.
    key_n = 1'b0;
    tick(5);
    aceito = 1'b1;
    tick(1);
    aceito = 1'b0;
    check("coin_valido", {7'h0, valido}, 8'h00);
    check("coin_estado", {6'h0, estado}, 8'h00);
    check("coin_a", {4'h0, a}, 8'h05);
    check("coin_sel", {5'h0, seletor}, 8'h01);
    key_n = 1'b1;
    tick(DEB + 4);
    check("coin_after_estado", {6'h0, estado}, 8'h00);
    check("coin_after_a", {4'h0, a}, 8'h05);

    // Unused selector code flags op_invalida only while in VALIDO.
    sw_dados = 4'h7;
    press();
    check("inv_a", {4'h0, a}, 8'h07);
    sw_dados = 4'h2;
    press();
    sw_op = 3'b110;
    press();
    check("inv_sel", {5'h0, seletor}, 8'h06);
    check("inv_opinv", {7'h0, op_invalida}, 8'h01);
    check("inv_estado", {6'h0, estado}, 8'h03);
    aceito = 1'b1;
    tick(1);
    aceito = 1'b0;
    check("inv_acc_opinv", {7'h0, op_invalida}, 8'h00);
    check("inv_acc_sel", {5'h0, seletor}, 8'h06);

    // Reset in CARREGA_B during a debounce in progress.
    sw_dados = 4'h4;
    press();
    check("pre_rst_estado", {6'h0, estado}, 8'h01);
    key_n = 1'b0;
    tick(3);
    rst   = 1'b1;
    key_n = 1'b1;
    tick(1);
    check_all_zero("rst_b");
    rst = 1'b0;
    tick(DEB + 4);
    check("post_rst_estado", {6'h0, estado}, 8'h00);
    check("post_rst_a", {4'h0, a}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
